// File: rtl/syn_pkg.sv
// Shared definitions for the synaptic current generator.
// Holds the current word format (Q8.8, 16-bit signed), saturation limits,
// the weight-write FSM state type, the axonal delay field width, and a
// saturating narrow-to-current helper.
package syn_pkg;

  localparam int CUR_W  = 16;  // width of the synaptic current word
  localparam int FRAC_W = 8;   // Q8.8 fraction bits
  localparam int DLY_W  = 2;   // axonal delay field, 0..3 extra cycles

  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } wstate_e;

  // Clamp a wide signed value into the current range; never wraps.
  function automatic logic signed [CUR_W-1:0] sat_cur(input logic signed [31:0] v);
    if (v > SAT_MAX)      return CUR_W'(SAT_MAX);
    else if (v < SAT_MIN) return CUR_W'(SAT_MIN);
    else                  return v[CUR_W-1:0];
  endfunction

endpackage

// File: rtl/synaptic_current_gen_if.sv
// Weight/config write channel of the synaptic current generator.
// Ports (signals):
//   w_valid  write request from the configuring master
//   w_ready  write accepted when w_valid & w_ready at the clock edge
//   w_addr   MSB=0 selects weight[idx], MSB=1 selects delay[idx]
//   w_data   signed write data (delay writes use bits [1:0])
interface synaptic_current_gen_if
  import syn_pkg::*;
#(
  parameter int N_IN = 4
) ();

  localparam int AW = $clog2(N_IN) + 1;

  logic                    w_valid;
  logic                    w_ready;
  logic [AW-1:0]           w_addr;
  logic signed [CUR_W-1:0] w_data;

  modport master (output w_valid, output w_addr, output w_data, input w_ready);
  modport slave  (input w_valid, input w_addr, input w_data, output w_ready);

endinterface

// File: rtl/spike_delay_line.sv
// Programmable axonal delay for one presynaptic event stream.
// A 3-deep shift register keeps every in-flight event independently; the
// select picks 0..3 cycles of extra delay.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   ev_in       edge-detected event for this input
//   sel         extra delay in cycles (0..3)
//   ev_out      delayed event
module spike_delay_line
  import syn_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             ev_in,
  input  logic [DLY_W-1:0] sel,
  output logic             ev_out
);

  logic [2:0] sr_q, sr_d;

  assign sr_d = {sr_q[1:0], ev_in};

  always_ff @(posedge clk) begin
    if (reset) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  always_comb begin
    unique case (sel)
      2'd0:    ev_out = ev_in;
      2'd1:    ev_out = sr_q[0];
      2'd2:    ev_out = sr_q[1];
      default: ev_out = sr_q[2];
    endcase
  end

endmodule

// File: rtl/synaptic_current_gen.sv
// Spike-to-current converter: edge-detects up to N_IN presynaptic spikes,
// adds the signed weight of every input with an event, and integrates them
// into one exponentially decaying Q8.8 current that saturates, never wraps.
// Optional feature macro: SYN_DELAY_EN adds a 0..3 cycle axonal delay per
// input; without it delay writes are accepted but have no effect.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   spike_in    presynaptic spike levels, one bit per source
//   wif         weight/delay write channel (slave side)
//   current     synaptic current to the neuron, Q8.8 signed
//   active      high when current != 0 (registered with current)
module synaptic_current_gen
  import syn_pkg::*;
#(
  parameter int                      N_IN      = 4,
  parameter int                      TAU_SHIFT = 3,
  parameter logic signed [CUR_W-1:0] W_INIT    = CUR_W'(1 << FRAC_W)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_IN-1:0]         spike_in,
  synaptic_current_gen_if.slave   wif,
  output logic signed [CUR_W-1:0] current,
  output logic                    active
);

  localparam int IDX_W = $clog2(N_IN);
  localparam int AW    = IDX_W + 1;
  localparam int SUM_W = CUR_W + IDX_W + 1;

  // ---------------- weight-write FSM ----------------
  wstate_e                 state_q;
  logic                    w_ready_q;
  logic [AW-1:0]           addr_q;
  logic signed [CUR_W-1:0] data_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      w_ready_q <= 1'b1;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (wif.w_valid) begin
          addr_q    <= wif.w_addr;
          data_q    <= wif.w_data;
          state_q   <= LOAD;
          w_ready_q <= 1'b0;
        end
        LOAD: begin
          state_q   <= IDLE;
          w_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign wif.w_ready = w_ready_q;

  logic wr_fire;
  assign wr_fire = (state_q == LOAD);

  // ---------------- weight registers ----------------
  logic signed [CUR_W-1:0] weight_q [N_IN];
  logic signed [CUR_W-1:0] weight_d [N_IN];

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    weight_d = weight_q;
    // Indices with no matching slot (idx >= N_IN) simply fall through.
    if (wr_fire && !addr_q[AW-1]) begin
      for (int i = 0; i < N_IN; i++) begin
        if (addr_q[IDX_W-1:0] == IDX_W'(i)) weight_d[i] = data_q;
      end
    end
  end

  // NOTE: the weights are a handful of flops, not a RAM, so they take a real
  // reset value; a RAM macro would not be reset this way.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_IN; i++) weight_q[i] <= W_INIT;
    end else begin
      weight_q <= weight_d;
    end
  end

  // ---------------- edge detect ----------------
  logic [N_IN-1:0] spike_q, spike_d, ev, ev_dly;

  assign spike_d = spike_in;
  assign ev      = spike_in & ~spike_q;

  always_ff @(posedge clk) begin
    if (reset) spike_q <= '0;
    else       spike_q <= spike_d;
  end

`ifdef SYN_DELAY_EN
  // ---------------- axonal delay ----------------
  logic [DLY_W-1:0] delay_q [N_IN];
  logic [DLY_W-1:0] delay_d [N_IN];

  always_comb begin
    delay_d = delay_q;
    if (wr_fire && addr_q[AW-1]) begin
      for (int i = 0; i < N_IN; i++) begin
        if (addr_q[IDX_W-1:0] == IDX_W'(i)) delay_d[i] = data_q[DLY_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_IN; i++) delay_q[i] <= '0;
    end else begin
      delay_q <= delay_d;
    end
  end

  for (genvar g = 0; g < N_IN; g++) begin : g_dly
    spike_delay_line u_dly (
      .clk    (clk),
      .reset  (reset),
      .ev_in  (ev[g]),
      .sel    (delay_q[g]),
      .ev_out (ev_dly[g])
    );
  end
`else
  assign ev_dly = ev;
`endif

  // ---------------- integrate and decay ----------------
  logic signed [CUR_W-1:0] current_q, current_d;
  logic                    active_q, active_d;
  logic signed [SUM_W-1:0] sum;
  logic signed [CUR_W:0]   cur_x, mag, m, decayed;
  logic signed [31:0]      total;

  always_comb begin
    sum = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (ev_dly[i]) sum = sum + SUM_W'(weight_q[i]);
    end

    // One extra bit so |-32768| is representable.
    cur_x = (CUR_W+1)'(current_q);
    mag   = current_q[CUR_W-1] ? -cur_x : cur_x;
    m     = mag >>> TAU_SHIFT;
    // Small values would otherwise stick forever; force at least one LSB.
    if (m == '0 && current_q != '0) m = (CUR_W+1)'(1);
    decayed = current_q[CUR_W-1] ? cur_x + m : cur_x - m;

    total     = 32'(decayed) + 32'(sum);
    current_d = sat_cur(total);
    active_d  = (current_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      current_q <= '0;
      active_q  <= 1'b0;
    end else begin
      current_q <= current_d;
      active_q  <= active_d;
    end
  end

  assign current = current_q;
  assign active  = active_q;

endmodule

// File: tb/tb_synaptic_current_gen.sv
// Self-checking bench for synaptic_current_gen (N_IN=4, TAU_SHIFT=3,
// W_INIT=256). Stimulus pushes hand-computed expectations tagged with the
// cycle they are due; a monitor on the falling edge pops and compares them.
module tb_synaptic_current_gen;
  import syn_pkg::*;

  localparam int N_IN = 4;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [N_IN-1:0]         spike_in = '0;
  logic signed [CUR_W-1:0] current;
  logic                    active;

  synaptic_current_gen_if #(.N_IN(N_IN)) wif ();

  synaptic_current_gen #(
    .N_IN      (N_IN),
    .TAU_SHIFT (3),
    .W_INIT    (16'sd256)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .spike_in (spike_in),
    .wif      (wif),
    .current  (current),
    .active   (active)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  int acc_cnt = 0;
  int n_tests = 0;
  int n_fail  = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  always @(posedge clk) if (wif.w_valid && wif.w_ready) acc_cnt <= acc_cnt + 1;

  // kind: 0 = current, 1 = active, 2 = w_ready
  typedef struct {
    int    cyc;
    int    kind;
    int    val;
    string name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   mon_i;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int n, input int kind, input int val, input string name);
    exp_t e;
    e.cyc  = cyc_cnt + n;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic exp_cur(input int n, input int val, input string name);
    push(n, 0, val, name);
    push(n, 1, (val != 0) ? 1 : 0, {name, "_active"});
  endtask

  task automatic exp_rdy(input int n, input int val, input string name);
    push(n, 2, val, name);
  endtask

  // Monitor: compare every expectation due at or before this cycle.
  always @(negedge clk) begin
    mon_i = 0;
    while (mon_i < exp_q.size()) begin
      if (exp_q[mon_i].cyc <= cyc_cnt) begin
        mon_e = exp_q[mon_i];
        exp_q.delete(mon_i);
        case (mon_e.kind)
          0:       check(mon_e.name, int'(current), mon_e.val);
          1:       check(mon_e.name, int'(active), mon_e.val);
          default: check(mon_e.name, int'(wif.w_ready), mon_e.val);
        endcase
      end else begin
        mon_i++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset(input int cycles, input string name);
    reset = 1'b1;
    steps(cycles);
    reset = 1'b0;
    exp_cur(0, 0, {name, "_cur"});
    exp_rdy(0, 1, {name, "_rdy"});
  endtask

  task automatic wr(input logic [2:0] addr, input logic signed [15:0] data);
    wif.w_valid = 1'b1;
    wif.w_addr  = addr;
    wif.w_data  = data;
    step();
    wif.w_valid = 1'b0;
    step();
  endtask

  initial begin
    int acc0;
    wif.w_valid = 1'b0;
    wif.w_addr  = '0;
    wif.w_data  = '0;

    // 1. reset and single pulse decay
    do_reset(2, "rst");
    spike_in = 4'b0001;
    exp_cur(1, 256, "pulse_c1");
    exp_cur(2, 224, "pulse_c2");
    exp_cur(3, 196, "pulse_c3");
    exp_cur(4, 172, "pulse_c4");
    step();
    spike_in = '0;
    steps(3);

    // 2. held level counts once, re-rise adds again
    do_reset(1, "rst2");
    spike_in = 4'b0010;
    exp_cur(1, 256, "held_c1");
    exp_cur(2, 224, "held_c2");
    exp_cur(3, 196, "held_c3");
    exp_cur(4, 172, "held_c4");
    exp_cur(5, 151, "held_c5");
    exp_cur(6, 133, "held_low");
    exp_cur(7, 373, "held_rerise");
    exp_cur(8, 327, "held_after");
    steps(5);
    spike_in = '0;
    step();
    spike_in = 4'b0010;
    step();
    spike_in = '0;
    step();

    // 3. saturation positive and negative
    do_reset(1, "rst3");
    wr(3'd0, 16'sd20000);
    wr(3'd1, 16'sd20000);
    spike_in = 4'b0011;
    exp_cur(1, 32767, "sat_pos");
    exp_cur(2, 28672, "sat_pos_decay");
    step();
    spike_in = '0;
    step();
    do_reset(1, "rst3n");
    wr(3'd0, -16'sd20000);
    wr(3'd1, -16'sd20000);
    spike_in = 4'b0011;
    exp_cur(1, -32768, "sat_neg");
    exp_cur(2, -28672, "sat_neg_decay");
    step();
    spike_in = '0;
    step();

    // 4. small negative tail reaches and holds zero
    do_reset(1, "rst4");
    wr(3'd2, -16'sd3);
    spike_in = 4'b0100;
    exp_cur(1, -3, "tail_c1");
    exp_cur(2, -2, "tail_c2");
    exp_cur(3, -1, "tail_c3");
    exp_cur(4, 0, "tail_c4");
    exp_cur(5, 0, "tail_c5");
    step();
    spike_in = '0;
    steps(4);

    // 5. handshake: w_valid held 3 cycles, two accepts
    do_reset(1, "rst5");
    exp_rdy(1, 0, "hs_rdy1");
    exp_rdy(2, 1, "hs_rdy2");
    exp_rdy(3, 0, "hs_rdy3");
    exp_rdy(4, 1, "hs_rdy4");
    acc0 = acc_cnt;
    wif.w_valid = 1'b1;
    wif.w_addr  = 3'd0;
    wif.w_data  = 16'sd100;
    steps(3);
    wif.w_valid = 1'b0;
    step();
    check("hs_accepts", acc_cnt - acc0, 2);
    // Address 5 writes nothing that matters; weight[1] must still be 256.
    wr(3'd5, 16'sd0);
    spike_in = 4'b0011;
    exp_cur(1, 356, "hs_sum");
    exp_cur(2, 312, "hs_sum_d1");
    exp_cur(3, 273, "hs_sum_d2");
    step();
    spike_in = '0;
    steps(2);

    // 5b. reset mid-decay
    do_reset(1, "rst5b");
    spike_in = 4'b0001;
    exp_cur(1, 256, "mid_c1");
    exp_cur(2, 224, "mid_c2");
    exp_cur(3, 196, "mid_c3");
    step();
    spike_in = '0;
    steps(2);
    reset = 1'b1;
    exp_cur(1, 0, "mid_reset");
    step();
    reset = 1'b0;

    // 7. event during the weight-write cycle uses the old weight
    do_reset(1, "rst7");
    wif.w_valid = 1'b1;
    wif.w_addr  = 3'd0;
    wif.w_data  = 16'sd500;
    step();
    wif.w_valid = 1'b0;
    spike_in = 4'b0001;
    exp_cur(1, 256, "oldw_c1");
    exp_cur(2, 224, "oldw_c2");
    exp_cur(3, 696, "neww_c3");
    step();
    spike_in = '0;
    step();
    spike_in = 4'b0001;
    step();
    spike_in = '0;

    // 6. axonal delay on input 3
    do_reset(1, "rst6");
    wr(3'd7, 16'sd2);
    spike_in = 4'b1000;
`ifdef SYN_DELAY_EN
    exp_cur(1, 0, "dly_c1");
    exp_cur(2, 0, "dly_c2");
    exp_cur(3, 256, "dly_c3");
    exp_cur(4, 224, "dly_c4");
`else
    exp_cur(1, 256, "dly_c1");
    exp_cur(2, 224, "dly_c2");
    exp_cur(3, 196, "dly_c3");
`endif
    step();
    spike_in = '0;
    steps(3);

    // drain outstanding expectations within a bounded number of cycles
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) step();
    check("drain_pending", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
